jam_cost_arbiter: RTL and testbench
===================================

Name: jam_cost_arbiter

Overview:
- Shares the single Cost lookup port (W/J out, Cost in) among NREQ evaluation engines, so several permutation/cost units can run in parallel in the JAM datapath.
- Round-robin arbitration, one lookup issued per cycle, fully pipelined.
- A requester can hold a lock for the consecutive lookups of one permutation, up to LOCK_MAX grants.
- Each requester gets its Cost back two cycles after the grant, tagged by a one-hot valid.

Parameters:
- NREQ, 2, number of requesters (2..4)
- LOCK_MAX, 8, maximum consecutive grants one owner can hold under lock

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-low reset
- req  input  NREQ  per-requester lookup request
- lock  input  NREQ  per-requester hold-grant request; ignored unless the matching req is high
- w_in  input  3*NREQ  worker index per requester; requester i uses bits [3i+2:3i]
- j_in  input  3*NREQ  job index per requester; same packing as w_in
- gnt  output  NREQ  combinational one-hot; gnt[i]=1 means requester i's w_in/j_in are captured at this edge
- W  output  3  registered worker index to the cost table
- J  output  3  registered job index to the cost table
- Cost  input  7  table data for the current W/J, valid in the same cycle
- rdata  output  7  registered Cost returned to requesters
- rvalid  output  NREQ  registered one-hot; marks the rdata owner

Behaviour:
- Reset (RST=0 at an edge): W=0, J=0, rdata=0, rvalid=0, rr_ptr=0, lock_cnt=0, state=OPEN.
  - gnt=0 while RST=0.
  - In-flight lookups are discarded: no rvalid appears after reset.
- Pipeline, with a grant in cycle t:
  - W/J hold the granted indices in cycle t+1, and Cost is sampled at the end of t+1.
  - rdata = that Cost and rvalid[i]=1 in cycle t+2.
  - Throughput is one grant per cycle; back-to-back grants give back-to-back rvalid.
- At most one gnt bit is set per cycle. gnt is 0 when no req is high. W/J keep their value on cycles with no grant.
- FSM state OPEN:
  - Grant the first requester with req=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - If the winner has lock=1: go to LOCKED, owner=winner, lock_cnt=1.
  - Otherwise: rr_ptr=(winner+1) mod NREQ and stay in OPEN.
- FSM state LOCKED, owner o:
  - If req[o]=1, lock[o]=1 and lock_cnt<LOCK_MAX: grant o and increment lock_cnt. Other requesters wait.
  - If req[o]=1 and lock[o]=0: grant o as its final grant, then rr_ptr=(o+1) mod NREQ, lock_cnt=0, go to OPEN.
  - If req[o]=0: release immediately. Arbitrate this cycle exactly as OPEN, with the search starting at (o+1) mod NREQ.
  - If lock_cnt=LOCK_MAX and req[o]=1: forced release. Arbitrate this cycle as OPEN from (o+1) mod NREQ, ignoring o's lock. If no one else requests, o may win again and the lock restarts with lock_cnt=1.
- lock_cnt is 4 bits wide and never exceeds LOCK_MAX.
- Changes to another requester's lock have no effect in LOCKED.
- rvalid and rdata are driven only by the pipeline; requesters never stall it (no back-pressure).

Test Plan:
- Reset then idle: RST=0 for 2 cycles, then req=0. Expect W=J=0, gnt=0, rvalid=0 throughout.
- Single lookup: req=01, w_in[2:0]=3, j_in[2:0]=5 in cycle 0, with Cost model = 8*W+J. Expect gnt=01 in cycle 0, W=3/J=5 in cycle 1, rdata=29 with rvalid=01 in cycle 2.
- Round-robin: req=11 with no lock, held for 4 cycles. Expect gnt sequence 01,10,01,10 and matching rvalid sequence two cycles later.
- Lock burst: req=11 and lock=01 for 10 cycles. Expect gnt=01 for 8 cycles (LOCK_MAX), then 10, then 01 with the lock restarting.
- Owner release: requester 1 locks, drops req after 3 grants while req0=1. Expect gnt=01 in that same cycle, then state OPEN with rr_ptr=1.
- Reset mid-flight: grants in cycles 0-1, RST=0 in cycle 1. Expect no rvalid in cycles 2-3, and all outputs at their reset values.

Source files
------------

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing the single Cost lookup port among NREQ engines,
// with optional bounded grant locking and a two-cycle tagged return pipeline.
module jam_cost_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [3*NREQ-1:0] w_in,
    input  logic [3*NREQ-1:0] j_in,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [6:0]        Cost,
    output logic [6:0]        rdata,
    output logic [NREQ-1:0]   rvalid
);
    localparam int unsigned   IW      = (NREQ > 2) ? 2 : 1;
    localparam logic [IW-1:0] LAST    = IW'(NREQ - 1);
    localparam logic [3:0]    CNT_MAX = 4'(LOCK_MAX);

    typedef enum logic {StOpen, StLocked} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [3:0]      lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] v1_q;

    logic [IW-1:0]   start, win_idx, owner_nxt;
    logic            open_arb, found, grant;
    int unsigned     idx;

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] x);
        return (x == LAST) ? '0 : x + IW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        owner_nxt  = inc_idx(owner_q);
        start      = rr_ptr_q;
        open_arb   = 1'b1;
        found      = 1'b0;
        grant      = 1'b0;
        win_idx    = owner_q;
        idx        = 0;

        if (state_q == StLocked) begin
            start = owner_nxt;
            if (req[owner_q] && (lock_cnt_q < CNT_MAX)) begin
                open_arb = 1'b0;
                grant    = 1'b1;
                win_idx  = owner_q;
                if (lock[owner_q]) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end else begin
                    state_d    = StOpen;
                    rr_ptr_d   = owner_nxt;
                    lock_cnt_d = '0;
                end
            end else begin
                // Owner dropped out or spent its budget: reopen this same cycle.
                state_d    = StOpen;
                rr_ptr_d   = owner_nxt;
                lock_cnt_d = '0;
            end
        end

        if (open_arb) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(start) + k) % NREQ;
                if (!found && req[IW'(idx)]) begin
                    found   = 1'b1;
                    win_idx = IW'(idx);
                end
            end
            if (found) begin
                grant = 1'b1;
                if (lock[win_idx]) begin
                    state_d    = StLocked;
                    owner_d    = win_idx;
                    lock_cnt_d = 4'd1;
                end else begin
                    state_d    = StOpen;
                    rr_ptr_d   = inc_idx(win_idx);
                    lock_cnt_d = '0;
                end
            end
        end

        if (!RST) begin
            grant = 1'b0;
        end
    end

    assign gnt = grant ? (NREQ'(1) << win_idx) : '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StOpen;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            v1_q       <= '0;
            W          <= '0;
            J          <= '0;
            rdata      <= '0;
            rvalid     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            v1_q       <= gnt;
            rvalid     <= v1_q;
            if (grant) begin
                W <= w_in[3*win_idx +: 3];
                J <= j_in[3*win_idx +: 3];
            end
            if (|v1_q) begin
                rdata <= Cost;
            end
        end
    end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter (NREQ=2, LOCK_MAX=8) with a Cost table of 8*W+J.
module tb_jam_cost_arbiter;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] lock = '0;
    logic [5:0] w_in = '0;
    logic [5:0] j_in = '0;
    logic [1:0] gnt, rvalid;
    logic [2:0] W, J;
    logic [6:0] Cost, rdata;

    int passed = 0;
    int total  = 0;

    logic [1:0] rr_g [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] lk_g [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b10, 2'b01, 2'b01};
    logic [1:0] ow_req [9] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [1:0] ow_lck [9] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0] ow_g [9]   = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

    jam_cost_arbiter #(.NREQ(2), .LOCK_MAX(8)) dut (
        .CLK(CLK), .RST(RST), .req(req), .lock(lock), .w_in(w_in), .j_in(j_in),
        .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rdata(rdata), .rvalid(rvalid)
    );

    // Cost table model: 8*W + J
    assign Cost = {1'b0, W, J};

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req = '0;
        lock = '0;
        next();
        RST = 1'b1;
    endtask

    initial begin
        // Reset then idle
        mid();
        chk("rst_gnt", 32'(gnt), 0);
        next();
        req = 2'b11;
        mid();
        chk("rst_gnt_req", 32'(gnt), 0);
        chk("rst_W", 32'(W), 0);
        chk("rst_J", 32'(J), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        next();
        RST = 1'b1;
        req = '0;
        for (int c = 0; c < 2; c++) begin
            mid();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_rvalid", 32'(rvalid), 0);
            chk("idle_W", 32'(W), 0);
            next();
        end

        // Single lookup: W=3, J=5 -> Cost 29
        req  = 2'b01;
        w_in = {3'd0, 3'd3};
        j_in = {3'd0, 3'd5};
        mid();
        chk("single_gnt", 32'(gnt), 32'b01);
        next();
        req = '0;
        mid();
        chk("single_gnt_idle", 32'(gnt), 0);
        chk("single_W", 32'(W), 3);
        chk("single_J", 32'(J), 5);
        chk("single_rvalid_t1", 32'(rvalid), 0);
        next();
        mid();
        chk("single_rvalid", 32'(rvalid), 32'b01);
        chk("single_rdata", 32'(rdata), 29);
        chk("single_W_hold", 32'(W), 3);
        next();

        // Round-robin: requester 0 -> Cost 15, requester 1 -> Cost 50
        do_reset();
        w_in = {3'd6, 3'd1};
        j_in = {3'd2, 3'd7};
        for (int c = 0; c < 6; c++) begin
            req = (c < 4) ? 2'b11 : 2'b00;
            mid();
            if (c < 4) chk("rr_gnt", 32'(gnt), 32'(rr_g[c]));
            else chk("rr_gnt_idle", 32'(gnt), 0);
            if (c >= 2) begin
                chk("rr_rvalid", 32'(rvalid), 32'(rr_g[c-2]));
                chk("rr_rdata", 32'(rdata), (rr_g[c-2] == 2'b01) ? 15 : 50);
            end
            next();
        end

        // Lock burst capped at 8, then forced release and relock
        for (int c = 0; c < 13; c++) begin
            req  = (c < 11) ? 2'b11 : 2'b00;
            lock = (c < 11) ? 2'b01 : 2'b00;
            mid();
            if (c < 11) chk("lock_gnt", 32'(gnt), 32'(lk_g[c]));
            else chk("lock_gnt_idle", 32'(gnt), 0);
            if (c >= 2) begin
                chk("lock_rvalid", 32'(rvalid), 32'(lk_g[c-2]));
                chk("lock_rdata", 32'(rdata), (lk_g[c-2] == 2'b01) ? 15 : 50);
            end
            next();
        end

        // Owner release, foreign lock ignored, unlocked final grant
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req  = ow_req[c];
            lock = ow_lck[c];
            mid();
            chk("owner_gnt", 32'(gnt), 32'(ow_g[c]));
            if (c >= 2) chk("owner_rvalid", 32'(rvalid), 32'(ow_g[c-2]));
            next();
        end

        // Reset mid-flight discards in-flight lookups
        req  = 2'b01;
        lock = 2'b00;
        mid();
        chk("mid_gnt", 32'(gnt), 32'b01);
        next();
        RST = 1'b0;
        req = 2'b11;
        mid();
        chk("mid_gnt_rst", 32'(gnt), 0);
        chk("mid_W_pre", 32'(W), 1);
        next();
        RST = 1'b1;
        req = 2'b00;
        mid();
        chk("mid_rvalid_t2", 32'(rvalid), 0);
        chk("mid_rdata", 32'(rdata), 0);
        chk("mid_W", 32'(W), 0);
        chk("mid_J", 32'(J), 0);
        chk("mid_gnt_t2", 32'(gnt), 0);
        next();
        mid();
        chk("mid_rvalid_t3", 32'(rvalid), 0);
        chk("mid_rdata_t3", 32'(rdata), 0);
        next();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
